// File: rtl/forward_ctrl_unit.sv
// Forwarding-select and load-use stall control for the 5-stage MIPS core.
// Optional stall counter enabled by defining FWD_STALL_CNT_EN.
module forward_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  pc_write,
`ifdef FWD_STALL_CNT_EN
    output logic                  ifid_write,
    output logic [CNT_W-1:0]      stall_count
`else
    output logic                  ifid_write
`endif
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
        logic                  rw;
        logic                  mr;
    } idex_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  rw;
    } wr_t;

    idex_t idex;
    wr_t   exmem;
    wr_t   memwb;

    function automatic logic [1:0] pick(
        input logic [REG_ADDR_W-1:0] src,
        input wr_t                   em,
        input wr_t                   mw
    );
        logic [1:0] s;
        s = 2'b00;
        if (em.rw && (em.dest != '0) && (em.dest == src))
            s = 2'b10;
        else if (mw.rw && (mw.dest != '0) && (mw.dest == src))
            s = 2'b01;
        return s;
    endfunction

    // Load-use hazard: load in EX feeding the instruction in ID
    always_comb begin
        stall = 1'b0;
        if (idex.mr && (idex.dest != '0) &&
            ((idex.dest == id_rs) || (idex.dest == id_rt)))
            stall = 1'b1;
        pc_write   = ~stall;
        ifid_write = ~stall;
    end

    // Operand selects depend only on the shadow registers
    always_comb begin
        fwd_a_sel = pick(idex.rs, exmem, memwb);
        fwd_b_sel = pick(idex.rt, exmem, memwb);
    end

    // Shadow pipeline: a stall or flush inserts a single bubble into EX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            memwb      <= exmem;
            exmem.dest <= idex.dest;
            exmem.rw   <= idex.rw;
            if (stall || flush) begin
                idex <= '0;
            end else begin
                idex.rs   <= id_rs;
                idex.rt   <= id_rt;
                idex.dest <= id_dest;
                idex.rw   <= id_reg_write;
                idex.mr   <= id_mem_read;
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    // Free-running count of stalled cycles, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (stall)
            stall_count <= stall_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// Bench for forward_ctrl_unit: in-order instruction model plus directed
// hazard sequences with literal expectations.
module tb_forward_ctrl_unit;

    localparam int RW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] id_rs = '0;
    logic [RW-1:0] id_rt = '0;
    logic [RW-1:0] id_dest = '0;
    logic          id_reg_write = 1'b0;
    logic          id_mem_read = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic          stall;
    logic          pc_write;
    logic          ifid_write;
`ifdef FWD_STALL_CNT_EN
    logic [CW-1:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    forward_ctrl_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_dest(id_dest),
        .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read),
        .flush(flush),
        .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel),
        .stall(stall),
        .pc_write(pc_write),
`ifdef FWD_STALL_CNT_EN
        .ifid_write(ifid_write),
        .stall_count(stall_count)
`else
        .ifid_write(ifid_write)
`endif
    );

    always #5 clk = ~clk;

    // Model: the instructions sitting in EX, MEM and WB
    typedef struct {
        int rs;
        int rt;
        int dest;
        bit wr;
        bit ld;
    } inst_t;

    inst_t  nop_i = '{0, 0, 0, 1'b0, 1'b0};
    inst_t  ex_i  = '{0, 0, 0, 1'b0, 1'b0};
    inst_t  mem_i = '{0, 0, 0, 1'b0, 1'b0};
    inst_t  wb_i  = '{0, 0, 0, 1'b0, 1'b0};
    longint m_cnt = 0;

    function automatic bit m_stall();
        if (!ex_i.ld || ex_i.dest == 0) return 1'b0;
        return (ex_i.dest == int'(id_rs)) || (ex_i.dest == int'(id_rt));
    endfunction

    function automatic int m_sel(input int src);
        if (src != 0 && mem_i.wr && mem_i.dest == src) return 2;
        if (src != 0 && wb_i.wr && wb_i.dest == src) return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_i  <= nop_i;
            mem_i <= nop_i;
            wb_i  <= nop_i;
            m_cnt <= 0;
        end else begin
            wb_i  <= mem_i;
            mem_i <= ex_i;
            if (m_stall()) m_cnt <= (m_cnt + 1) % (64'd1 << CW);
            if (m_stall() || flush)
                ex_i <= nop_i;
            else
                ex_i <= '{int'(id_rs), int'(id_rt), int'(id_dest),
                          id_reg_write, id_mem_read};
        end
    end

    task automatic cmp(input string name, input longint got,
                       input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want,
                     $time);
        end
    endtask

    // Every negedge the outputs are compared with the model
    always @(negedge clk) begin
        cmp("m_a_sel", fwd_a_sel, m_sel(ex_i.rs));
        cmp("m_b_sel", fwd_b_sel, m_sel(ex_i.rt));
        cmp("m_stall", stall, m_stall());
        cmp("m_pc_write", pc_write, !m_stall());
        cmp("m_ifid_write", ifid_write, !m_stall());
`ifdef FWD_STALL_CNT_EN
        cmp("m_count", stall_count, m_cnt);
`endif
    end

    // Present one instruction in ID just after the next rising edge
    task automatic issue(input int rs, input int rt, input int dest,
                         input bit wr, input bit ld, input bit fl);
        @(posedge clk);
        #2;
        id_rs        = RW'(rs);
        id_rt        = RW'(rt);
        id_dest      = RW'(dest);
        id_reg_write = wr;
        id_mem_read  = ld;
        flush        = fl;
    endtask

    task automatic nop();
        issue(0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        repeat (3) nop();
    endtask

    task automatic expect_out(input string name, input int a, input int b,
                              input bit st);
        #1;
        cmp({name, "_a"}, fwd_a_sel, a);
        cmp({name, "_b"}, fwd_b_sel, b);
        cmp({name, "_stall"}, stall, st);
        cmp({name, "_pcw"}, pc_write, !st);
    endtask

    initial begin
        reset = 1'b1;
        expect_out("rst_init", 0, 0, 1'b0);
        #1 reset = 1'b0;

        // add $3; add $4,$3,$5
        issue(1, 2, 3, 1'b1, 1'b0, 1'b0);
        issue(3, 5, 4, 1'b1, 1'b0, 1'b0);
        nop();
        expect_out("exmem_a", 2, 0, 1'b0);
        drain();

        // add $3; nop; sub $6,$1,$3
        issue(1, 2, 3, 1'b1, 1'b0, 1'b0);
        nop();
        issue(1, 3, 6, 1'b1, 1'b0, 1'b0);
        nop();
        expect_out("memwb_b", 0, 1, 1'b0);
        drain();

        // add $3; add $3; or $7,$3,$3
        issue(1, 2, 3, 1'b1, 1'b0, 1'b0);
        issue(4, 5, 3, 1'b1, 1'b0, 1'b0);
        issue(3, 3, 7, 1'b1, 1'b0, 1'b0);
        nop();
        expect_out("prio", 2, 2, 1'b0);
        drain();

        // lw $2; add $5,$2,$2
        issue(1, 0, 2, 1'b1, 1'b1, 1'b0);
        issue(2, 2, 5, 1'b1, 1'b0, 1'b0);
        expect_out("lu_stall", 0, 0, 1'b1);
        issue(2, 2, 5, 1'b1, 1'b0, 1'b0);
        expect_out("lu_bubble", 0, 0, 1'b0);
        nop();
        expect_out("lu_fwd", 1, 1, 1'b0);
        drain();

        // load feeding only rt
        issue(1, 0, 9, 1'b1, 1'b1, 1'b0);
        issue(4, 9, 5, 1'b1, 1'b0, 1'b0);
        expect_out("lu_rt", 0, 0, 1'b1);
        drain();

        // writes to $0 never forward; load to $0 never stalls
        issue(1, 2, 0, 1'b1, 1'b0, 1'b0);
        issue(0, 0, 5, 1'b1, 1'b0, 1'b0);
        nop();
        expect_out("zero_fwd", 0, 0, 1'b0);
        issue(1, 0, 0, 1'b1, 1'b1, 1'b0);
        issue(0, 0, 6, 1'b1, 1'b0, 1'b0);
        expect_out("zero_ld", 0, 0, 1'b0);
        drain();

        // lw $2 flushed: only a bubble, nothing to forward
        issue(1, 0, 2, 1'b1, 1'b1, 1'b1);
        issue(2, 2, 5, 1'b1, 1'b0, 1'b0);
        expect_out("flush_ld", 0, 0, 1'b0);
        nop();
        expect_out("flush_fwd", 0, 0, 1'b0);
        drain();

        // stall and flush together: a single bubble
        issue(1, 0, 2, 1'b1, 1'b1, 1'b0);
        issue(2, 0, 5, 1'b1, 1'b0, 1'b1);
        expect_out("sf_stall", 0, 0, 1'b1);
        issue(2, 0, 5, 1'b1, 1'b0, 1'b0);
        expect_out("sf_after", 0, 0, 1'b0);
        nop();
        expect_out("sf_fwd", 1, 0, 1'b0);
        drain();

        // reset mid-stream with a load pending in EX
        issue(1, 0, 2, 1'b1, 1'b1, 1'b0);
        issue(2, 2, 5, 1'b1, 1'b0, 1'b0);
        expect_out("pre_rst", 0, 0, 1'b1);
        reset = 1'b1;
        expect_out("mid_rst", 0, 0, 1'b0);
        #1 reset = 1'b0;
        drain();

`ifdef FWD_STALL_CNT_EN
        @(posedge clk);
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            issue(1, 0, 2, 1'b1, 1'b1, 1'b0);
            issue(2, 3, 5, 1'b1, 1'b0, 1'b0);
            issue(2, 3, 5, 1'b1, 1'b0, 1'b0);
            nop();
        end
        drain();
        #1 cmp("stall_count", stall_count, 3);
`endif

        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
